// File: rtl/regfile_scoreboard_mp_pkg.sv
// Shared defaults and helpers for the scoreboarded multi-port register file.
package regfile_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned ZERO_REG   = 0;

  function automatic int unsigned nregs(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_mp_if.sv
// Write, reserve, flush and read-port bundle between ID/WB logic and the register file.
interface regfile_scoreboard_mp_if
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned NRD    = 2
);

  logic                  RegWre;
  logic [ADDR_W-1:0]     WriteReg;
  logic [DATA_W-1:0]     WriteData;
  logic                  ReserveEn;
  logic [ADDR_W-1:0]     ReserveReg;
  logic                  Flush;
  logic [NRD*ADDR_W-1:0] ReadRegs;
  logic [NRD*DATA_W-1:0] ReadData;
  logic [NRD-1:0]        ReadBusy;

  modport master (
    output RegWre, WriteReg, WriteData, ReserveEn, ReserveReg, Flush, ReadRegs,
    input  ReadData, ReadBusy
  );

  modport slave (
    input  RegWre, WriteReg, WriteData, ReserveEn, ReserveReg, Flush, ReadRegs,
    output ReadData, ReadBusy
  );

endinterface

// File: rtl/regfile_scoreboard_mp_busy_tracker.sv
// Per-register busy scoreboard: set on reserve, cleared on writeback, bulk-cleared on flush.
module regfile_busy_tracker
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        RegWre,
  input  logic [ADDR_W-1:0]           WriteReg,
  input  logic                        ReserveEn,
  input  logic [ADDR_W-1:0]           ReserveReg,
  input  logic                        Flush,
  output logic [nregs(ADDR_W)-1:0]    busy
);

  logic [nregs(ADDR_W)-1:0] busy_nxt;

  // Reserve is applied after release so a same-cycle new producer wins.
  always_comb begin
    busy_nxt = busy;
    if (RegWre && (WriteReg != ADDR_W'(ZERO_REG))) begin
      busy_nxt[WriteReg] = 1'b0;
    end
    if (ReserveEn && (ReserveReg != ADDR_W'(ZERO_REG))) begin
      busy_nxt[ReserveReg] = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset || Flush) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

endmodule

// File: rtl/regfile_scoreboard_mp.sv
// Parametrised N-read register file with busy scoreboard; r0 reads as zero.
// Optional write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_scoreboard_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned NRD    = 2
) (
  input  logic                   Clk,
  input  logic                   Reset,
  regfile_scoreboard_mp_if.slave bus
);

  localparam int unsigned NREGS = nregs(ADDR_W);

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;

  regfile_busy_tracker #(
    .ADDR_W (ADDR_W)
  ) u_busy (
    .Clk        (Clk),
    .Reset      (Reset),
    .RegWre     (bus.RegWre),
    .WriteReg   (bus.WriteReg),
    .ReserveEn  (bus.ReserveEn),
    .ReserveReg (bus.ReserveReg),
    .Flush      (bus.Flush),
    .busy       (busy)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.RegWre && (bus.WriteReg != ADDR_W'(ZERO_REG))) begin
      regs[bus.WriteReg] <= bus.WriteData;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              bsy;

    assign addr = bus.ReadRegs[k*ADDR_W +: ADDR_W];

    always_comb begin
      data = '0;
      bsy  = 1'b0;
      if (addr != ADDR_W'(ZERO_REG)) begin
        data = regs[addr];
        bsy  = busy[addr];
`ifdef REGFILE_BYPASS_EN
        // Forward the value being written back this cycle; it also retires the producer.
        if (bus.RegWre && (bus.WriteReg == addr)) begin
          data = bus.WriteData;
          bsy  = 1'b0;
        end
`endif
      end
    end

    assign bus.ReadData[k*DATA_W +: DATA_W] = data;
    assign bus.ReadBusy[k]                  = bsy;
  end

endmodule

// File: tb/tb_regfile_scoreboard_mp.sv
// Randomised self-checking bench for regfile_scoreboard_mp (2x32b and 4x64b instances).
module tb_regfile_scoreboard_mp;

  logic Clk = 1'b0;
  logic rst2, rst4;
  always #5 Clk = ~Clk;

  regfile_scoreboard_mp_if #(.DATA_W(32), .ADDR_W(5), .NRD(2)) bus2 ();
  regfile_scoreboard_mp_if #(.DATA_W(64), .ADDR_W(5), .NRD(4)) bus4 ();

  regfile_scoreboard_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2)) dut2 (
    .Clk(Clk), .Reset(rst2), .bus(bus2.slave));
  regfile_scoreboard_mp #(.DATA_W(64), .ADDR_W(5), .NRD(4)) dut4 (
    .Clk(Clk), .Reset(rst4), .bus(bus4.slave));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state per instance: d=0 -> 2x32b, d=1 -> 4x64b
  logic [63:0] mreg  [2][32];
  logic        mbusy [2][32];
  logic        cur_rst [2];
  logic        cur_we  [2];
  logic [4:0]  cur_wr  [2];
  logic [63:0] cur_wd  [2];
  logic        cur_re  [2];
  logic [4:0]  cur_rr  [2];
  logic        cur_fl  [2];

  function automatic int nrd(input int d);
    return (d == 0) ? 2 : 4;
  endfunction

  function automatic logic [63:0] exp_rd(input int d, input logic [4:0] a);
    if (a == 5'd0) return 64'd0;
`ifdef REGFILE_BYPASS_EN
    if (cur_we[d] && cur_wr[d] == a)
      return (d == 0) ? {32'd0, cur_wd[d][31:0]} : cur_wd[d];
`endif
    return mreg[d][a];
  endfunction

  function automatic logic exp_busy(input int d, input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (cur_we[d] && cur_wr[d] == a) return 1'b0;
`endif
    return mbusy[d][a];
  endfunction

  function automatic logic [63:0] act_rd(input int d, input int k);
    if (d == 0) return {32'd0, bus2.ReadData[k*32 +: 32]};
    return bus4.ReadData[k*64 +: 64];
  endfunction

  function automatic logic act_busy(input int d, input int k);
    if (d == 0) return bus2.ReadBusy[k];
    return bus4.ReadBusy[k];
  endfunction

  task automatic set_rd(input int d, input int k, input logic [4:0] a);
    if (d == 0) bus2.ReadRegs[k*5 +: 5] = a;
    else        bus4.ReadRegs[k*5 +: 5] = a;
  endtask

  task automatic drive(input int d, input logic rst, input logic we, input logic [4:0] wr,
                       input logic [63:0] wd, input logic re, input logic [4:0] rr,
                       input logic fl);
    cur_rst[d] = rst; cur_we[d] = we; cur_wr[d] = wr; cur_wd[d] = wd;
    cur_re[d]  = re;  cur_rr[d] = rr; cur_fl[d] = fl;
    if (d == 0) begin
      rst2 = rst; bus2.RegWre = we; bus2.WriteReg = wr; bus2.WriteData = wd[31:0];
      bus2.ReserveEn = re; bus2.ReserveReg = rr; bus2.Flush = fl;
    end else begin
      rst4 = rst; bus4.RegWre = we; bus4.WriteReg = wr; bus4.WriteData = wd;
      bus4.ReserveEn = re; bus4.ReserveReg = rr; bus4.Flush = fl;
    end
  endtask

  // Advance one edge and apply the priority rules to the reference state.
  task automatic tick(input int d);
    @(posedge Clk);
    if (cur_rst[d]) begin
      for (int i = 0; i < 32; i++) begin mreg[d][i] = 64'd0; mbusy[d][i] = 1'b0; end
    end else begin
      if (cur_we[d] && cur_wr[d] != 5'd0)
        mreg[d][cur_wr[d]] = (d == 0) ? {32'd0, cur_wd[d][31:0]} : cur_wd[d];
      if (cur_fl[d]) begin
        for (int i = 0; i < 32; i++) mbusy[d][i] = 1'b0;
      end else begin
        if (cur_we[d] && cur_wr[d] != 5'd0) mbusy[d][cur_wr[d]] = 1'b0;
        if (cur_re[d] && cur_rr[d] != 5'd0) mbusy[d][cur_rr[d]] = 1'b1;
      end
    end
    #1;
    drive(d, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic step(input int d, input logic rst, input logic we, input logic [4:0] wr,
                      input logic [63:0] wd, input logic re, input logic [4:0] rr,
                      input logic fl);
    drive(d, rst, we, wr, wd, re, rr, fl);
    tick(d);
  endtask

  task automatic test_reset();
    // Reset with write/reserve also asserted: both must be ignored.
    step(0, 1'b1, 1'b1, 5'd3, 64'hFFFF_FFFF, 1'b1, 5'd3, 1'b0);
    for (int a = 0; a < 32; a++) begin
      set_rd(0, 0, 5'(a));
      set_rd(0, 1, 5'(31 - a));
      #1;
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (act_rd(0, k) !== 64'd0 || act_busy(0, k) !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_clear addr_port%0d data=%h busy=%b required 0/0", k,
                   act_rd(0, k), act_busy(0, k));
        end
      end
    end
  endtask

  task automatic test_write();
    step(0, 1'b0, 1'b1, 5'd5, 64'hDEAD_BEEF, 1'b0, 5'd0, 1'b0);
    step(0, 1'b0, 1'b1, 5'd0, 64'h1234, 1'b0, 5'd0, 1'b0);
    set_rd(0, 0, 5'd5); set_rd(0, 1, 5'd5); #1;
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (act_rd(0, k) !== 64'hDEAD_BEEF) begin
        n_fail++;
        $display("FAIL write_r5 port%0d got=%h required=deadbeef", k, act_rd(0, k));
      end
    end
    set_rd(0, 0, 5'd0); #1;
    n_tests++;
    if (act_rd(0, 0) !== 64'd0) begin
      n_fail++;
      $display("FAIL write_r0 got=%h required=0", act_rd(0, 0));
    end
  endtask

  task automatic test_reserve();
    set_rd(0, 0, 5'd7); set_rd(0, 1, 5'd7);
    step(0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 1'b0);
    n_tests++;
    if (act_busy(0, 0) !== 1'b1) begin
      n_fail++; $display("FAIL reserve_r7 busy=%b required=1", act_busy(0, 0));
    end
    step(0, 1'b0, 1'b1, 5'd7, 64'hA5, 1'b0, 5'd0, 1'b0);
    n_tests++;
    if (act_busy(0, 1) !== 1'b0 || act_rd(0, 1) !== 64'hA5) begin
      n_fail++;
      $display("FAIL release_r7 busy=%b data=%h required 0/a5", act_busy(0, 1), act_rd(0, 1));
    end
    step(0, 1'b0, 1'b1, 5'd7, 64'hA5, 1'b1, 5'd7, 1'b0);
    n_tests++;
    if (act_busy(0, 0) !== 1'b1 || act_rd(0, 0) !== 64'hA5) begin
      n_fail++;
      $display("FAIL reserve_and_write_r7 busy=%b data=%h required 1/a5",
               act_busy(0, 0), act_rd(0, 0));
    end
  endtask

  task automatic test_flush();
    step(0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd3, 1'b0);
    step(0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd4, 1'b0);
    step(0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 1'b0);
    step(0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd10, 1'b1);
    for (int a = 0; a < 32; a++) begin
      set_rd(0, 0, 5'(a)); #1;
      n_tests++;
      if (act_busy(0, 0) !== 1'b0 || act_rd(0, 0) !== mreg[0][a]) begin
        n_fail++;
        $display("FAIL flush r%0d busy=%b data=%h required 0/%h", a, act_busy(0, 0),
                 act_rd(0, 0), mreg[0][a]);
      end
    end
  endtask

  task automatic test_bypass();
    step(0, 1'b0, 1'b1, 5'd12, 64'h77, 1'b0, 5'd0, 1'b0);
    step(0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd12, 1'b0);
    set_rd(0, 0, 5'd12); set_rd(0, 1, 5'd12);
    drive(0, 1'b0, 1'b1, 5'd12, 64'h55, 1'b0, 5'd0, 1'b0);
    #1;
    for (int k = 0; k < 2; k++) begin
      n_tests++;
`ifdef REGFILE_BYPASS_EN
      if (act_rd(0, k) !== 64'h55 || act_busy(0, k) !== 1'b0) begin
        n_fail++;
        $display("FAIL bypass_same_cycle port%0d data=%h busy=%b required 55/0", k,
                 act_rd(0, k), act_busy(0, k));
      end
`else
      if (act_rd(0, k) !== 64'h77 || act_busy(0, k) !== 1'b1) begin
        n_fail++;
        $display("FAIL nobypass_same_cycle port%0d data=%h busy=%b required 77/1", k,
                 act_rd(0, k), act_busy(0, k));
      end
`endif
    end
    tick(0);
    n_tests++;
    if (act_rd(0, 0) !== 64'h55 || act_busy(0, 0) !== 1'b0) begin
      n_fail++;
      $display("FAIL write_r12_next data=%h busy=%b required 55/0", act_rd(0, 0),
               act_busy(0, 0));
    end
  endtask

  task automatic test_random(input int d, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      logic [4:0] wr;
      wr = 5'($urandom);
      drive(d, ($urandom_range(0, 39) == 0), 1'($urandom), wr, {$urandom, $urandom},
            1'($urandom), 5'($urandom), ($urandom_range(0, 9) == 0));
      for (int k = 0; k < nrd(d); k++)
        set_rd(d, k, ($urandom_range(0, 2) == 0) ? wr : 5'($urandom));
      #1;
      for (int k = 0; k < nrd(d); k++) begin
        logic [4:0] a;
        a = (d == 0) ? bus2.ReadRegs[k*5 +: 5] : bus4.ReadRegs[k*5 +: 5];
        n_tests++;
        if (act_rd(d, k) !== exp_rd(d, a) || act_busy(d, k) !== exp_busy(d, a)) begin
          n_fail++;
          $display("FAIL random d%0d cyc%0d port%0d r%0d data=%h busy=%b required %h/%b",
                   d, c, k, a, act_rd(d, k), act_busy(d, k), exp_rd(d, a), exp_busy(d, a));
        end
      end
      tick(d);
    end
  endtask

  task automatic test_wide();
    logic [4:0]  addr [4];
    logic [63:0] val  [4];
    step(1, 1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      addr[k] = 5'(4 * k + 1 + $urandom_range(0, 3));
      val[k]  = {$urandom, $urandom};
      step(1, 1'b0, 1'b1, addr[k], val[k], 1'b0, 5'd0, 1'b0);
    end
    for (int k = 0; k < 4; k++) set_rd(1, k, addr[k]);
    #1;
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (act_rd(1, k) !== val[k]) begin
        n_fail++;
        $display("FAIL wide_read port%0d got=%h required=%h", k, act_rd(1, k), val[k]);
      end
    end
    step(1, 1'b1, 1'b1, addr[0], 64'hCAFE_F00D_1234_5678, 1'b1, addr[1], 1'b0);
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (act_rd(1, k) !== 64'd0 || act_busy(1, k) !== 1'b0) begin
        n_fail++;
        $display("FAIL wide_reset port%0d data=%h busy=%b required 0/0", k,
                 act_rd(1, k), act_busy(1, k));
      end
    end
  endtask

  initial begin
    drive(0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0);
    drive(1, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0);
    bus2.ReadRegs = '0;
    bus4.ReadRegs = '0;
    #1;
    test_reset();
    test_write();
    test_reserve();
    test_flush();
    test_bypass();
    test_random(0, 400);
    test_wide();
    test_random(1, 200);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
